hsv_core_alu_stage: RTL and testbench

// - Integer ALU execution unit of the hsv core (implements hsv_core_alu_t ops from hsv_core_pkg).
// - Sits between issue (alu_data_t, valid/ready in) and commit (commit_data_t, valid/ready out).
// - Computes add/sub, signed/unsigned compare, AND/OR/XOR and shifts; forwards pc/illegal to commit.
// - Flushable on request from the core's flush controller.

---
 rtl/hsv_core_alu_stage.sv | 208 ++++++++++++++++++++
 tb/tb_hsv_core_alu_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hsv_core_alu_stage.sv
// hsv_core_alu_stage: integer ALU (add/sub, compare, logic, shifts) between issue and commit.
// Latency 1 cycle; 2 cycles when HSV_ALU_PIPE2_EN is defined (extra register before the result mux).
// Valid/ready in and out; a stalled output holds commit_data; flush_req blocks input and empties the stage.
package hsv_core_pkg;
  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    ALU_BITWISE_AND  = 2'd0,
    ALU_BITWISE_OR   = 2'd1,
    ALU_BITWISE_XOR  = 2'd2,
    ALU_BITWISE_PASS = 2'd3
  } hsv_core_alu_bitwise_t;

  typedef enum logic {
    ALU_OUT_ADDER = 1'b0,
    ALU_OUT_SHIFT = 1'b1
  } hsv_core_alu_out_t;

  typedef struct packed {
    logic                  negate;
    logic                  flip_signs;
    logic                  compare;
    logic                  sign_extend;
    logic                  is_immediate;
    logic                  pc_relative;
    hsv_core_alu_bitwise_t bitwise_select;
    hsv_core_alu_out_t     out_select;
  } hsv_core_alu_t;

  typedef struct packed {
    word_t pc;
    word_t rs1;
    word_t rs2;
    word_t immediate;
    logic  illegal;
  } common_data_t;

  typedef struct packed {
    hsv_core_alu_t alu;
    common_data_t  common;
  } alu_data_t;

  typedef struct packed {
    word_t        result;
    common_data_t common;
    logic         exception;
  } commit_data_t;
endpackage

module hsv_core_alu_stage
  import hsv_core_pkg::*;
(
  input  logic         clk_core,
  input  logic         rst_core_n,
  input  logic         flush_req,
  output logic         flush_ack,
  input  alu_data_t    alu_data,
  input  logic         valid_i,
  output logic         ready_o,
  output commit_data_t commit_data,
  output logic         valid_o,
  input  logic         ready_i
);

  word_t        w_a;
  word_t        w_b;
  word_t        w_b_eff;
  word_t        w_sum;
  word_t        w_bitwise;
  word_t        w_shift;
  logic [4:0]   w_shamt;
  logic         w_lt;
  logic         w_accept;

  logic         r_vld;
  logic         r_flush_ack;
  commit_data_t r_commit;

  assign w_a     = alu_data.alu.pc_relative  ? alu_data.common.pc        : alu_data.common.rs1;
  assign w_b     = alu_data.alu.is_immediate ? alu_data.common.immediate : alu_data.common.rs2;
  assign w_b_eff = alu_data.alu.negate ? (~w_b + 1'b1) : w_b;
  assign w_sum   = w_a + w_b_eff;
  assign w_shamt = w_b[4:0];

  // Flipping both sign bits turns the signed comparison into an unsigned one.
  assign w_lt = $signed({w_a[XLEN-1] ^ alu_data.alu.flip_signs, w_a[XLEN-2:0]}) <
                $signed({w_b[XLEN-1] ^ alu_data.alu.flip_signs, w_b[XLEN-2:0]});

  always_comb begin
    w_bitwise = w_a;
    unique case (alu_data.alu.bitwise_select)
      ALU_BITWISE_AND:  w_bitwise = w_a & w_b;
      ALU_BITWISE_OR:   w_bitwise = w_a | w_b;
      ALU_BITWISE_XOR:  w_bitwise = w_a ^ w_b;
      ALU_BITWISE_PASS: w_bitwise = w_a;
    endcase
  end

  always_comb begin
    w_shift = w_bitwise;
    if (alu_data.alu.bitwise_select == ALU_BITWISE_PASS) begin
      if (!alu_data.alu.negate)
        w_shift = w_a << w_shamt;
      else if (alu_data.alu.sign_extend)
        w_shift = $signed(w_a) >>> w_shamt;
      else
        w_shift = w_a >> w_shamt;
    end
  end

  function automatic word_t f_result(input hsv_core_alu_out_t osel, input logic cmp,
                                     input logic ill, input word_t sum, input logic lt,
                                     input word_t shf);
    if (ill)
      return '0;
    if (osel == ALU_OUT_SHIFT)
      return shf;
    if (cmp)
      return {{(XLEN-1){1'b0}}, lt};
    return sum;
  endfunction

  assign w_accept = valid_i & ready_o;

  // flush_req clears every stage at the edge it is sampled, so the stage is empty one cycle later.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n)
      r_flush_ack <= 1'b0;
    else
      r_flush_ack <= flush_req;
  end

`ifdef HSV_ALU_PIPE2_EN
  typedef struct packed {
    word_t             sum;
    logic              lt;
    word_t             shf;
    logic              compare;
    hsv_core_alu_out_t out_select;
    common_data_t      common;
  } s1_t;

  logic r_s1_vld;
  s1_t  r_s1;
  logic w_s1_adv;

  assign w_s1_adv = ~r_vld | ready_i;
  assign ready_o  = ~flush_req & (~r_s1_vld | w_s1_adv);

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_s1_vld <= 1'b0;
      r_s1     <= '0;
      r_vld    <= 1'b0;
      r_commit <= '0;
    end else if (flush_req) begin
      r_s1_vld <= 1'b0;
      r_vld    <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_commit.result    <= f_result(r_s1.out_select, r_s1.compare, r_s1.common.illegal,
                                         r_s1.sum, r_s1.lt, r_s1.shf);
          r_commit.common    <= r_s1.common;
          r_commit.exception <= r_s1.common.illegal;
        end
      end
      if (w_accept) begin
        r_s1_vld        <= 1'b1;
        r_s1.sum        <= w_sum;
        r_s1.lt         <= w_lt;
        r_s1.shf        <= w_shift;
        r_s1.compare    <= alu_data.alu.compare;
        r_s1.out_select <= alu_data.alu.out_select;
        r_s1.common     <= alu_data.common;
      end else if (w_s1_adv) begin
        r_s1_vld <= 1'b0;
      end
    end
  end
`else
  assign ready_o = ~flush_req & (~r_vld | ready_i);

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_vld    <= 1'b0;
      r_commit <= '0;
    end else if (flush_req) begin
      r_vld <= 1'b0;
    end else if (w_accept) begin
      r_vld              <= 1'b1;
      r_commit.result    <= f_result(alu_data.alu.out_select, alu_data.alu.compare,
                                     alu_data.common.illegal, w_sum, w_lt, w_shift);
      r_commit.common    <= alu_data.common;
      r_commit.exception <= alu_data.common.illegal;
    end else if (ready_i) begin
      r_vld <= 1'b0;
    end
  end
`endif

  assign valid_o     = r_vld;
  assign commit_data = r_commit;
  assign flush_ack   = r_flush_ack;

endmodule

// File: tb/tb_hsv_core_alu_stage.sv
// Directed self-checking bench for hsv_core_alu_stage (default single-stage build).
module tb_hsv_core_alu_stage;
  import hsv_core_pkg::*;

  logic         clk_core = 1'b0;
  logic         rst_core_n = 1'b0;
  logic         flush_req = 1'b0;
  logic         flush_ack;
  alu_data_t    alu_data = '0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  commit_data_t commit_data;
  logic         valid_o;
  logic         ready_i = 1'b1;

  int checks = 0;
  int errors = 0;

  hsv_core_alu_stage dut (
    .clk_core    (clk_core),
    .rst_core_n  (rst_core_n),
    .flush_req   (flush_req),
    .flush_ack   (flush_ack),
    .alu_data    (alu_data),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .commit_data (commit_data),
    .valid_o     (valid_o),
    .ready_i     (ready_i)
  );

  always #5 clk_core = ~clk_core;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic alu_data_t mk(input word_t pc, input word_t rs1, input word_t rs2,
                                   input word_t imm, input logic ill, input logic neg,
                                   input logic flip, input logic cmp, input logic sext,
                                   input logic isimm, input logic pcrel,
                                   input hsv_core_alu_bitwise_t bsel,
                                   input hsv_core_alu_out_t osel);
    alu_data_t d;
    d.common.pc            = pc;
    d.common.rs1           = rs1;
    d.common.rs2           = rs2;
    d.common.immediate     = imm;
    d.common.illegal       = ill;
    d.alu.negate           = neg;
    d.alu.flip_signs       = flip;
    d.alu.compare          = cmp;
    d.alu.sign_extend      = sext;
    d.alu.is_immediate     = isimm;
    d.alu.pc_relative      = pcrel;
    d.alu.bitwise_select   = bsel;
    d.alu.out_select       = osel;
    return d;
  endfunction

  // One op with an idle output: accepted at the next edge, visible one cycle later, then drained.
  task automatic run_op(input string tag, input alu_data_t d, input word_t exp_res,
                        input logic exp_exc);
    alu_data = d;
    valid_i  = 1'b1;
    @(posedge clk_core); #1;
    valid_i = 1'b0;
    chk({tag, "_vld"}, 32'(valid_o), 32'd1);
    chk({tag, "_res"}, commit_data.result, exp_res);
    chk({tag, "_exc"}, 32'(commit_data.exception), 32'(exp_exc));
    chk({tag, "_pc"}, commit_data.common.pc, d.common.pc);
    @(posedge clk_core); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk_core);
    #1;
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_flush_ack", 32'(flush_ack), 32'd0);
    chk("rst_result", commit_data.result, 32'd0);
    chk("rst_ready_o", 32'(ready_o), 32'd1);
    rst_core_n = 1'b1;
    @(posedge clk_core); #1;
    chk("idle_valid_o", 32'(valid_o), 32'd0);

    run_op("and", mk(32'h100, 32'h10, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                     ALU_BITWISE_AND, ALU_OUT_SHIFT), 32'h10, 1'b0);
    run_op("or_imm", mk(32'h104, 32'h5A5A5A5A, 32'h0, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                        1'b1, 1'b0, ALU_BITWISE_OR, ALU_OUT_SHIFT), 32'h5A5A5A5A, 1'b0);
    run_op("xor", mk(32'h108, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b0, ALU_BITWISE_XOR, ALU_OUT_SHIFT), 32'hF0F0F0F0, 1'b0);
    run_op("slt", mk(32'h10C, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                     ALU_BITWISE_PASS, ALU_OUT_ADDER), 32'h1, 1'b0);
    run_op("sltu", mk(32'h110, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                      ALU_BITWISE_PASS, ALU_OUT_ADDER), 32'h0, 1'b0);
    run_op("sub", mk(32'h114, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                     ALU_BITWISE_PASS, ALU_OUT_ADDER), 32'hFFFFFFFE, 1'b0);
    run_op("add_pc", mk(32'h1000, 32'h7, 32'h9, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                        ALU_BITWISE_PASS, ALU_OUT_ADDER), 32'h1020, 1'b0);
    run_op("add_wrap", mk(32'h118, 32'hFFFFFFFF, 32'h2, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                          1'b0, ALU_BITWISE_PASS, ALU_OUT_ADDER), 32'h1, 1'b0);
    run_op("sra", mk(32'h11C, 32'h80000000, 32'h4, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                     ALU_BITWISE_PASS, ALU_OUT_SHIFT), 32'hF8000000, 1'b0);
    run_op("srl", mk(32'h120, 32'h80000000, 32'h4, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                     ALU_BITWISE_PASS, ALU_OUT_SHIFT), 32'h08000000, 1'b0);
    run_op("sll", mk(32'h124, 32'h1, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                     ALU_BITWISE_PASS, ALU_OUT_SHIFT), 32'h10, 1'b0);
    run_op("sll_shamt5", mk(32'h128, 32'h1, 32'h24, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            ALU_BITWISE_PASS, ALU_OUT_SHIFT), 32'h10, 1'b0);
    run_op("illegal", mk(32'h12C, 32'h5, 32'h6, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                         ALU_BITWISE_PASS, ALU_OUT_ADDER), 32'h0, 1'b1);

    // Back-to-back with ready_i high: full throughput.
    alu_data = mk(32'h200, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  ALU_BITWISE_PASS, ALU_OUT_ADDER);
    valid_i = 1'b1;
    @(posedge clk_core); #1;
    chk("b2b_res0", commit_data.result, 32'h3);
    chk("b2b_rdy", 32'(ready_o), 32'd1);
    alu_data = mk(32'h204, 32'h10, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  ALU_BITWISE_PASS, ALU_OUT_ADDER);
    @(posedge clk_core); #1;
    valid_i = 1'b0;
    chk("b2b_vld1", 32'(valid_o), 32'd1);
    chk("b2b_res1", commit_data.result, 32'h30);
    @(posedge clk_core); #1;
    chk("b2b_drain", 32'(valid_o), 32'd0);

    // Backpressure: output held for 5 cycles while a second op waits.
    ready_i  = 1'b0;
    alu_data = mk(32'h300, 32'h3, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  ALU_BITWISE_PASS, ALU_OUT_ADDER);
    valid_i  = 1'b1;
    @(posedge clk_core); #1;
    alu_data = mk(32'h304, 32'hA, 32'h14, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  ALU_BITWISE_PASS, ALU_OUT_ADDER);
    for (int i = 0; i < 5; i++) begin
      chk("stall_vld", 32'(valid_o), 32'd1);
      chk("stall_res", commit_data.result, 32'h7);
      chk("stall_pc", commit_data.common.pc, 32'h300);
      chk("stall_rdy", 32'(ready_o), 32'd0);
      @(posedge clk_core); #1;
    end
    ready_i = 1'b1;
    #1;
    chk("release_rdy", 32'(ready_o), 32'd1);
    @(posedge clk_core); #1;
    valid_i = 1'b0;
    chk("release_vld", 32'(valid_o), 32'd1);
    chk("release_res", commit_data.result, 32'h1E);
    @(posedge clk_core); #1;
    chk("release_drain", 32'(valid_o), 32'd0);

    // Flush with an op in flight and another offered during the flush.
    ready_i  = 1'b0;
    alu_data = mk(32'h400, 32'h1, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  ALU_BITWISE_PASS, ALU_OUT_ADDER);
    valid_i  = 1'b1;
    @(posedge clk_core); #1;
    chk("fl_inflight", 32'(valid_o), 32'd1);
    flush_req = 1'b1;
    #1;
    chk("fl_rdy_comb", 32'(ready_o), 32'd0);
    @(posedge clk_core); #1;
    chk("fl_vld", 32'(valid_o), 32'd0);
    chk("fl_ack", 32'(flush_ack), 32'd1);
    chk("fl_rdy", 32'(ready_o), 32'd0);
    ready_i = 1'b1;
    @(posedge clk_core); #1;
    chk("fl_ignored", 32'(valid_o), 32'd0);
    chk("fl_ack_hold", 32'(flush_ack), 32'd1);
    flush_req = 1'b0;
    valid_i   = 1'b0;
    @(posedge clk_core); #1;
    chk("fl_ack_drop", 32'(flush_ack), 32'd0);
    chk("fl_post_vld", 32'(valid_o), 32'd0);
    chk("fl_post_rdy", 32'(ready_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
